alu_share_ctrl: RTL and testbench

- Sequences the single shared combinational ALU between two requesters: requester 0 is the main datapath and requester 1 is the branch/address unit.
- Arbitrates round-robin and latches operands, then drives the ALU control and data inputs.
- Holds multiply operations stable for MUL_LAT cycles to model a multi-cycle multiplier.
- Returns a registered result with a one-cycle done pulse to the winning requester.

---
 rtl/alu_share_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer for one shared combinational ALU.
// Two requesters (0 = main datapath, 1 = branch/address unit) compete for
// the ALU. The winner's op and operands are latched and drive the ALU for
// one cycle, or for MUL_LAT cycles on multiply. The result is then
// registered and returned with a one-cycle done pulse.
module alu_share_ctrl #(
  parameter int W       = 32,
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [3:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [3:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic         busy,
  output logic [3:0]   alu_cntrl,
  output logic [W-1:0] data_1,
  output logic [W-1:0] data_2,
  input  logic [W-1:0] alu_out,
  input  logic         zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_e       state_q, state_d;
  logic         rr_q, rr_d;
  logic         id_q, id_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   cntrl_q, cntrl_d;
  logic [W-1:0] d1_q, d1_d;
  logic [W-1:0] d2_q, d2_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_zero_q, rsp_zero_d;
  logic         rsp_err_q, rsp_err_d;

  logic         gnt_id;
  logic [3:0]   gnt_op;

  // Winner when in IDLE: lone requester, else the round-robin pointer.
  always_comb begin
    gnt_id = (req0 && req1) ? rr_q : req1;
    gnt_op = gnt_id ? op1 : op0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: latched grant, ALU drive, response and arbiter pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      cntrl_q    <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      cntrl_q    <= cntrl_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic: grant in IDLE, count down in EXEC, release in RESP.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    cntrl_d    = cntrl_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          id_d    = gnt_id;
          cntrl_d = gnt_op;
          d1_d    = gnt_id ? a1 : a0;
          d2_d    = gnt_id ? b1 : b0;
          cnt_d   = (gnt_op == OP_MUL) ? MUL_CNT : '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Illegal ops report a fixed zero result so whatever the ALU
          // produced for an unknown code never reaches the requester.
          if (cntrl_q <= OP_MUL) begin
            rsp_data_d = alu_out;
            rsp_zero_d = zero;
            rsp_err_d  = 1'b0;
          end else begin
            rsp_data_d = '0;
            rsp_zero_d = 1'b1;
            rsp_err_d  = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        rr_d    = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: done pulses decoded from RESP, everything else from registers.
  always_comb begin
    done0     = (state_q == RESP) && !id_q;
    done1     = (state_q == RESP) &&  id_q;
    busy      = (state_q != IDLE);
    rsp_data  = rsp_data_q;
    rsp_zero  = rsp_zero_q;
    rsp_err   = rsp_err_q;
    alu_cntrl = cntrl_q;
    data_1    = d1_q;
    data_2    = d2_q;
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed vector table, reset and
// contention sequences, then randomized traffic against a transaction model.
module tb_alu_share_ctrl;
  localparam int W       = 32;
  localparam int MUL_LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rq [2];
  logic [3:0]   opv[2];
  logic [W-1:0] av [2];
  logic [W-1:0] bv [2];
  logic         done0, done1, rsp_zero, rsp_err, busy, zero;
  logic [W-1:0] rsp_data, data_1, data_2, alu_out;
  logic [3:0]   alu_cntrl;
  logic         req0, req1;

  assign req0 = rq[0];
  assign req1 = rq[1];

  always #5 clk = ~clk;

  alu_share_ctrl #(.W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(opv[0]), .a0(av[0]), .b0(bv[0]),
    .req1(req1), .op1(opv[1]), .a1(av[1]), .b1(bv[1]),
    .done0(done0), .done1(done1), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .busy(busy), .alu_cntrl(alu_cntrl),
    .data_1(data_1), .data_2(data_2), .alu_out(alu_out), .zero(zero)
  );

  // External ALU; unknown codes return junk that must never be forwarded.
  always_comb begin
    case (alu_cntrl)
      4'b0000: alu_out = data_1 & data_2;
      4'b0001: alu_out = data_1 | data_2;
      4'b0010: alu_out = data_1 + data_2;
      4'b0011: alu_out = data_1 - data_2;
      4'b0100: alu_out = data_1 * data_2;
      default: alu_out = 32'hDEAD_BEEF ^ data_1;
    endcase
  end
  assign zero = (alu_out == '0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         z;
    logic         e;
  } res_t;

  function automatic res_t ref_calc(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    r.e = 1'b0;
    case (op)
      4'd0: r.d = a & b;
      4'd1: r.d = a | b;
      4'd2: r.d = a + b;
      4'd3: r.d = a - b;
      4'd4: r.d = a * b;
      default: begin
        r.d = '0;
        r.e = 1'b1;
      end
    endcase
    r.z = r.e ? 1'b1 : (r.d == '0);
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (op == 4'd4) ? MUL_LAT + 1 : 2;
  endfunction

  typedef struct {
    int           id;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_d;
    logic         exp_z;
    logic         exp_e;
    int           exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    int n;
    int busy_n;
    bit got;
    logic dn_own, dn_oth;
    @(negedge clk);
    rq[v.id] = 1'b1; opv[v.id] = v.op; av[v.id] = v.a; bv[v.id] = v.b;
    rq[1 - v.id] = 1'b0;
    n = 0; busy_n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      // Requester-side changes after the grant must not reach the ALU.
      opv[v.id] = v.op ^ 4'b1001; av[v.id] = ~v.a; bv[v.id] = v.b + 32'd3;
      if (busy) busy_n++;
      dn_own = (v.id == 0) ? done0 : done1;
      dn_oth = (v.id == 0) ? done1 : done0;
      chk("done_other", dn_oth, 1'b0);
      if (dn_own) begin
        got = 1;
      end else if (busy) begin
        chk("hold_cntrl", alu_cntrl, v.op);
        chk("hold_d1", data_1, v.a);
        chk("hold_d2", data_2, v.b);
      end
    end
    chk("latency", n, v.exp_lat);
    chk("busy_cycles", busy_n, v.exp_lat);
    chk("rsp_data", rsp_data, v.exp_d);
    chk("rsp_zero", rsp_zero, v.exp_z);
    chk("rsp_err", rsp_err, v.exp_e);
    rq[v.id] = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", {done1, done0}, 2'b00);
    chk("rsp_hold", rsp_data, v.exp_d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int ndone;
    int st[2];
    logic [W-1:0] ord;
    bit   m_active;
    int   m_left;
    logic m_ptr;
    logic m_w;
    res_t m_res, m_rsp;
    bit   was_active;
    logic dn[2];
    logic exp_dn;

    vecs[0] = '{0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 2};
    vecs[1] = '{1, 4'b0011, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0, 2};
    vecs[2] = '{0, 4'b0100, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, MUL_LAT + 1};
    vecs[3] = '{1, 4'b1010, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 2};
    vecs[4] = '{0, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 2};
    vecs[5] = '{1, 4'b0001, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0, 1'b0, 2};
    vecs[6] = '{0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 2};
    vecs[7] = '{1, 4'b0100, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, MUL_LAT + 1};
    vecs[8] = '{0, 4'b1111, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, 2};
    vecs[9] = '{1, 4'b0011, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 2};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; opv[i] = '0; av[i] = '0; bv[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_done", {done1, done0}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp", {rsp_zero, rsp_err}, 2'b00);
    chk("rst_data", rsp_data, '0);
    chk("rst_drive", {alu_cntrl, data_1, data_2} == '0, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset during the second EXEC cycle of a multiply.
    @(negedge clk);
    rq[0] = 1'b1; opv[0] = 4'b0100; av[0] = 32'd6; bv[0] = 32'd7;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", {done1, done0}, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rsp", {rsp_data, rsp_zero, rsp_err} == '0, 1'b1);
    chk("mid_rst_drive", {alu_cntrl, data_1, data_2} == '0, 1'b1);
    rq[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_nodone", {done1, done0}, 2'b00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_nodone", {done1, done0}, 2'b00);
    rq[1] = 1'b1; opv[1] = 4'b0010; av[1] = 32'd3; bv[1] = 32'd4;
    n = 0;
    while (!done1 && n < 20) begin
      @(negedge clk);
      n++;
      chk("post_rst_done0", done0, 1'b0);
    end
    chk("post_rst_lat", n, 2);
    chk("post_rst_data", rsp_data, 32'd7);
    rq[1] = 1'b0;
    @(negedge clk);

    // Contention after a fresh reset: pointer starts at requester 0.
    do_reset();
    @(negedge clk);
    rq[0] = 1'b1; opv[0] = 4'b0010; av[0] = 32'd1; bv[0] = 32'd1;
    rq[1] = 1'b1; opv[1] = 4'b0010; av[1] = 32'd2; bv[1] = 32'd2;
    st[0] = 0; st[1] = 0;
    ndone = 0; n = 0;
    while (ndone < 4 && n < 60) begin
      @(negedge clk);
      n++;
      dn[0] = done0; dn[1] = done1;
      chk("cont_both_done", done0 && done1, 1'b0);
      for (int r = 0; r < 2; r++) begin
        if (dn[r]) begin
          ord = r;
          chk("cont_order", ord, ndone % 2);
          chk("cont_data", rsp_data, (r == 0) ? 32'd2 : 32'd4);
          ndone++;
          rq[r] = 1'b0; st[r] = 1;
        end else if (st[r] == 1) begin
          st[r] = 2;
        end else if (st[r] == 2) begin
          rq[r] = 1'b1; st[r] = 0;
        end
      end
    end
    chk("cont_count", ndone, 4);

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_active = 0; m_left = 0; m_ptr = 1'b0; m_w = 1'b0;
    m_rsp = '{'0, 1'b0, 1'b0};
    m_res = m_rsp;
    st[0] = 0; st[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      was_active = m_active;
      exp_dn = 1'b0;
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          exp_dn = 1'b1;
          m_rsp = m_res;
          m_ptr = ~m_w;
          m_active = 0;
        end
      end
      chk("rnd_busy", busy, was_active);
      chk("rnd_done0", done0, exp_dn && (m_w == 1'b0));
      chk("rnd_done1", done1, exp_dn && (m_w == 1'b1));
      chk("rnd_rsp_data", rsp_data, m_rsp.d);
      chk("rnd_rsp_flags", {rsp_zero, rsp_err}, {m_rsp.z, m_rsp.e});
      dn[0] = done0; dn[1] = done1;
      for (int r = 0; r < 2; r++) begin
        if (dn[r]) begin
          rq[r] = 1'b0; st[r] = 1;
        end else if (st[r] == 1) begin
          st[r] = 0;
        end else if (!rq[r]) begin
          if ($urandom_range(0, 2) != 0) begin
            rq[r] = 1'b1;
            n = $urandom_range(0, 7);
            opv[r] = (n < 5) ? 4'(n) : 4'($urandom_range(5, 15));
            av[r] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
            bv[r] = ($urandom_range(0, 3) == 0) ? av[r] : $urandom();
          end
        end else if (m_active && (m_w == 1'(r))) begin
          opv[r] = 4'($urandom()); av[r] = $urandom(); bv[r] = $urandom();
        end
      end
      if (!was_active && (rq[0] || rq[1])) begin
        m_w = (rq[0] && rq[1]) ? m_ptr : rq[1];
        m_res = ref_calc(opv[m_w], av[m_w], bv[m_w]);
        m_left = ref_lat(opv[m_w]);
        m_active = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
